// File: rtl/reg_file_cc_pkg.sv
// Shared LC-3 datapath constants for the register file and condition codes.
package reg_file_cc_pkg;

    // Native LC-3 word width.
    localparam int LC3_DATA_W = 16;

    // Register address width (R0-R7).
    localparam int REG_ADDR_W = 3;

    // Condition-code bit positions within the NZP vector.
    localparam int CC_N_BIT = 2;
    localparam int CC_Z_BIT = 1;
    localparam int CC_P_BIT = 0;

    // Reset value of the condition codes: Z set, NZP order.
    localparam logic [2:0] CC_RESET = 3'b010;

endpackage

// File: rtl/reg_file_cc_if.sv
// Bus between the datapath controller and the register file / CC block.
interface reg_file_cc_if
    import reg_file_cc_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W
);
    // Writeback side
    logic [DATA_W-1:0]     busIn;
    logic                  ldReg;
    logic [REG_ADDR_W-1:0] DR;
    logic                  ldCC;

    // Read side
    logic [REG_ADDR_W-1:0] SR1;
    logic [REG_ADDR_W-1:0] SR2;
    logic [DATA_W-1:0]     Ra;
    logic [DATA_W-1:0]     Rb;

    // Condition codes
    logic                  N;
    logic                  Z;
    logic                  P;

    // Controller / datapath driving the register file
    modport master (
        output busIn, ldReg, DR, ldCC, SR1, SR2,
        input  Ra, Rb, N, Z, P
    );

    // Register file itself
    modport slave (
        input  busIn, ldReg, DR, ldCC, SR1, SR2,
        output Ra, Rb, N, Z, P
    );

endinterface

// File: rtl/reg_file_cc_nzp_gen.sv
// Combinational sign classification of a two's-complement word into one-hot NZP.
module nzp_gen
    import reg_file_cc_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W
) (
    input  logic [DATA_W-1:0] value,
    output logic [2:0]        nzp
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (value == '0);
    assign is_neg  = value[DATA_W-1];

    // Exactly one bit is set for any input: zero wins only when MSB is clear anyway.
    always_comb begin
        nzp           = '0;
        nzp[CC_N_BIT] = is_neg;
        nzp[CC_Z_BIT] = is_zero;
        nzp[CC_P_BIT] = !is_neg && !is_zero;
    end

endmodule

// File: rtl/reg_file_cc.sv
// LC-3 general-purpose register file with write-through read bypass and
// registered N/Z/P condition codes derived from the writeback bus.
module reg_file_cc
    import reg_file_cc_pkg::*;
#(
    parameter int DATA_W   = LC3_DATA_W,
    parameter int NUM_REGS = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    reg_file_cc_if.slave  rf
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [2:0]        cc_q;
    logic [2:0]        nzp_next;
    logic [DATA_W-1:0] ra_d;
    logic [DATA_W-1:0] rb_d;

    nzp_gen #(
        .DATA_W (DATA_W)
    ) u_nzp_gen (
        .value (rf.busIn),
        .nzp   (nzp_next)
    );

    // Storage and CC update; reset clears everything and discards any
    // coincident register or CC load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            cc_q <= CC_RESET;
        end else begin
            if (rf.ldReg) begin
                regs[rf.DR] <= rf.busIn;
            end
            if (rf.ldCC) begin
                cc_q <= nzp_next;
            end
        end
    end

    // Combinational reads; a same-cycle write to the addressed register is
    // forwarded so the ALU sees the value being written. This stays active
    // during reset because it does not depend on stored state.
    always_comb begin
        ra_d = regs[rf.SR1];
        rb_d = regs[rf.SR2];
        if (rf.ldReg && (rf.DR == rf.SR1)) begin
            ra_d = rf.busIn;
        end
        if (rf.ldReg && (rf.DR == rf.SR2)) begin
            rb_d = rf.busIn;
        end
    end

    assign rf.Ra = ra_d;
    assign rf.Rb = rb_d;

    // CC outputs come straight from the register: no bypass of a pending load.
    assign rf.N = cc_q[CC_N_BIT];
    assign rf.Z = cc_q[CC_Z_BIT];
    assign rf.P = cc_q[CC_P_BIT];

endmodule

// File: tb/tb_reg_file_cc.sv
// Directed-vector bench for reg_file_cc: table of per-cycle stimuli with
// hand-computed pre-edge expectations, plus a hold sequence for CC and regs.
module tb_reg_file_cc;

    localparam int DW = 16;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    reg_file_cc_if #(.DATA_W(DW)) rf ();

    reg_file_cc #(
        .DATA_W   (DW),
        .NUM_REGS (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          ld_reg;
        logic [2:0]    dr;
        logic          ld_cc;
        logic [DW-1:0] bus;
        logic [2:0]    sr1;
        logic [2:0]    sr2;
        logic [DW-1:0] exp_ra;
        logic [DW-1:0] exp_rb;
        logic [2:0]    exp_nzp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic ld_reg, logic [2:0] dr, logic ld_cc,
                                logic [DW-1:0] bus, logic [2:0] sr1, logic [2:0] sr2,
                                logic [DW-1:0] exp_ra, logic [DW-1:0] exp_rb,
                                logic [2:0] exp_nzp);
        vec_t v;
        v.rst_n = rst_n; v.ld_reg = ld_reg; v.dr = dr; v.ld_cc = ld_cc; v.bus = bus;
        v.sr1 = sr1; v.sr2 = sr2; v.exp_ra = exp_ra; v.exp_rb = exp_rb; v.exp_nzp = exp_nzp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset_n     = v.rst_n;
        rf.ldReg    = v.ld_reg;
        rf.DR       = v.dr;
        rf.ldCC     = v.ld_cc;
        rf.busIn    = v.bus;
        rf.SR1      = v.sr1;
        rf.SR2      = v.sr2;
    endtask

    // Checks the settled outputs of the current cycle, then steps past the edge.
    task automatic check_cycle(input string tag, input logic [DW-1:0] era,
                               input logic [DW-1:0] erb, input logic [2:0] enzp);
        #3;
        check({tag, " Ra"}, 32'(rf.Ra), 32'(era));
        check({tag, " Rb"}, 32'(rf.Rb), 32'(erb));
        check({tag, " NZP"}, 32'({rf.N, rf.Z, rf.P}), 32'(enzp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Stimulus: rst_n ldReg DR ldCC busIn SR1 SR2 | Ra Rb NZP (before the edge)
        // Read-all-addresses after reset
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 7, 16'h0000, 16'h0000, 3'b010));
        vecs.push_back(mk(1, 0, 0, 0, 16'hAAAA, 1, 6, 16'h0000, 16'h0000, 3'b010));
        vecs.push_back(mk(1, 0, 0, 0, 16'h5555, 2, 5, 16'h0000, 16'h0000, 3'b010));
        vecs.push_back(mk(1, 0, 0, 0, 16'hFFFF, 3, 4, 16'h0000, 16'h0000, 3'b010));
        // R3 <= 1234, not read this cycle
        vecs.push_back(mk(1, 1, 3, 0, 16'h1234, 0, 1, 16'h0000, 16'h0000, 3'b010));
        vecs.push_back(mk(1, 0, 3, 0, 16'h0000, 3, 3, 16'h1234, 16'h1234, 3'b010));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 2, 4, 16'h0000, 16'h0000, 3'b010));
        // Bypass on port A only
        vecs.push_back(mk(1, 1, 5, 0, 16'hBEEF, 5, 3, 16'hBEEF, 16'h1234, 3'b010));
        vecs.push_back(mk(1, 0, 5, 0, 16'h0000, 5, 5, 16'hBEEF, 16'hBEEF, 3'b010));
        // CC sequence: each NZP visible one cycle after its load
        vecs.push_back(mk(1, 0, 0, 1, 16'h8000, 5, 0, 16'hBEEF, 16'h0000, 3'b010));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0000, 5, 0, 16'hBEEF, 16'h0000, 3'b100));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0001, 5, 0, 16'hBEEF, 16'h0000, 3'b010));
        vecs.push_back(mk(1, 0, 0, 1, 16'h7FFF, 5, 0, 16'hBEEF, 16'h0000, 3'b001));
        vecs.push_back(mk(1, 0, 0, 0, 16'h8000, 5, 0, 16'hBEEF, 16'h0000, 3'b001));
        // Combined reg + CC load, bypass on both ports with SR1==SR2
        vecs.push_back(mk(1, 1, 1, 1, 16'h8001, 1, 1, 16'h8001, 16'h8001, 3'b001));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 3, 16'h8001, 16'h1234, 3'b100));
        // Reset with coincident writes: bypass still visible, writes discarded
        vecs.push_back(mk(0, 1, 2, 1, 16'hFFFF, 2, 3, 16'hFFFF, 16'h1234, 3'b100));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 2, 3, 16'h0000, 16'h0000, 3'b010));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 5, 1, 16'h0000, 16'h0000, 3'b010));

        // Initial reset
        drive(mk(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b010));
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check_cycle($sformatf("vec%0d", i), vecs[i].exp_ra, vecs[i].exp_rb, vecs[i].exp_nzp);
        end

        // Put known data in R7 and N into the CC, then hold both for 10 cycles.
        drive(mk(1, 1, 7, 1, 16'hC0DE, 0, 0, 16'h0000, 16'h0000, 3'b010));
        check_cycle("load7", 16'h0000, 16'h0000, 3'b010);
        for (int c = 0; c < 10; c++) begin
            logic [DW-1:0] b;
            b = (c % 3 == 0) ? 16'h0000 : ((c % 3 == 1) ? 16'h0001 : DW'($urandom));
            drive(mk(1, 0, 3'(c), 0, b, 7, 3'(c), 16'h0000, 16'h0000, 3'b000));
            // Only R7 holds data after the reset above
            check_cycle($sformatf("hold%0d", c), 16'hC0DE,
                        (3'(c) == 3'd7) ? 16'hC0DE : 16'h0000, 3'b100);
        end

        // Every address reads 0 except R7 on both ports, with no write pending.
        for (int a = 0; a < 8; a++) begin
            drive(mk(1, 0, 0, 0, 16'h0000, 3'(a), 3'(7 - a), 16'h0000, 16'h0000, 3'b000));
            check_cycle($sformatf("scan%0d", a),
                        (a == 7) ? 16'hC0DE : 16'h0000,
                        (a == 0) ? 16'hC0DE : 16'h0000, 3'b100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
